avalon_st_pkt_source: RTL
=========================

Name: avalon_st_pkt_source

Overview:
- Synthesizable Avalon-ST source (transmit end) for 256-bit streaming links. Complements the sink-side bench interface.
- Accepts packet commands (length, seed) on a valid/ready command port and emits one packet per command.
- Packets carry SOP/EOP/empty framing and a deterministic incrementing byte payload.
- Used as on-chip traffic generator and as DUT stimulus in sink-side VIP benches; readyLatency = 0.

Parameters:
- DATA_BYTES, 32, symbols (bytes) per beat; data width = 8*DATA_BYTES; fixed 32 in this release.
- EMPTY_W, 5, width of empty; log2(DATA_BYTES).
- LEN_W, 16, width of cmd_len in bytes.
- IDLE_GAP, 0, idle cycles inserted after each packet's EOP beat before next command is accepted (0..255).

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_len  input  LEN_W  packet length in bytes; 0 = drop.
- cmd_seed  input  8  first payload byte value.
- data  output  256  stream data; byte 0 of beat in data[255:248].
- valid  output  1  beat valid.
- ready  input  1  sink ready; beat transfers when valid & ready at posedge.
- startofpacket  output  1  first beat of packet.
- endofpacket  output  1  last beat of packet.
- empty  output  EMPTY_W  unused bytes in EOP beat; 0 otherwise.
- pkt_done  output  1  one-cycle pulse on cycle after EOP beat transfers.
- pkt_count  output  32  packets completed, wraps at 2^32.

Behaviour:
- Reset (async assert, sync deassert expected upstream): all outputs 0 except cmd_ready = 0. FSM = IDLE. Counters cleared. Any in-flight packet is abandoned with no EOP.
- FSM states:
  - IDLE: cmd_ready = 1, valid = 0.
    - On cmd handshake with cmd_len != 0: latch len/seed, go SEND.
    - On cmd handshake with cmd_len == 0: consume, stay IDLE; no beat, no pkt_done, no count.
  - SEND: valid = 1, cmd_ready = 0.
    - First beat has startofpacket = 1.
    - On each transfer, advance byte offset by 32.
    - On EOP transfer: go GAP if IDLE_GAP > 0, else IDLE.
  - GAP: valid = 0, cmd_ready = 0; counts IDLE_GAP cycles, then IDLE.
- Latency:
  - cmd handshake at edge N -> valid = 1 in the cycle after edge N.
  - cmd_ready is 0 from edge N until the FSM returns to IDLE.
  - Minimum spacing between commands with IDLE_GAP = 0 is 1 idle cycle after EOP.
- Source rules:
  - While valid = 1 and ready = 0, data/sop/eop/empty held stable.
  - valid never deasserts mid-packet.
  - Outputs are registered.
- Payload: byte at packet offset i = (cmd_seed + i) mod 256; wraps 0xFF -> 0x00.
- Beats = ceil(len/32).
- EOP beat:
  - empty = (32 - len mod 32) mod 32.
  - Unused low-order bytes driven 0x00.
- Single-beat packet (len <= 32): sop and eop both 1 on the same beat.
- Max len 65535 -> 2048 beats, empty = 1.
- pkt_done pulses exactly once per non-zero packet, the cycle after the EOP transfer. pkt_count increments on the same edge.
- Outside SEND: data = 0, sop = eop = 0, empty = 0.
- Reset asserted mid-packet: valid drops immediately (asynchronous). After release, FSM is in IDLE awaiting a new command.

Test Plan:
- len = 32, seed = 0x10, ready = 1 -> one beat, sop = eop = 1, empty = 0, data[255:248] = 0x10, data[7:0] = 0x2F, pkt_done 1 cycle later, pkt_count = 1.
- len = 70, seed = 0xF0, ready = 1 -> 3 beats:
  - beat0 byte0 = 0xF0, byte16 = 0x00 (wrap).
  - beat2 eop = 1, empty = 26, bytes 0..5 = 0x30..0x35, remaining bytes 0.
- len = 100, ready toggled 1,0,0,1,0,1… -> beats 4, empty = 28, each beat held stable while ready = 0, valid never drops mid-packet.
- cmd_len = 0 then len = 1 -> first command consumed silently. Second yields one beat, sop = eop = 1, empty = 31. pkt_count = 1.
- IDLE_GAP = 3, back-to-back commands len = 64 -> cmd_ready returns 1 exactly 3 cycles after the pkt_done cycle boundary. Second packet sop follows next.
- reset pulsed during beat 2 of len = 256 packet -> valid/sop/eop go 0 immediately, pkt_count = 0, next command len = 32 transmits correctly.

Source files
------------

// File: rtl/avalon_st_pkt_source.sv
// Avalon-ST packet source for 256-bit links. Each accepted command (length, seed)
// becomes one SOP/EOP/empty-framed packet whose payload bytes count up from the seed.
module avalon_st_pkt_source #(
    parameter int DATA_BYTES = 32,
    parameter int EMPTY_W    = 5,
    parameter int LEN_W      = 16,
    parameter int IDLE_GAP   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [7:0]              cmd_seed,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    valid,
    input  logic                    ready,
    output logic                    startofpacket,
    output logic                    endofpacket,
    output logic [EMPTY_W-1:0]      empty,
    output logic                    pkt_done,
    output logic [31:0]             pkt_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    // Loaded on EOP so the GAP state lasts exactly IDLE_GAP cycles.
    localparam logic [7:0] GAP_LOAD = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_rem;
    logic [7:0]         r_byte;
    logic               r_sop;
    logic [7:0]         r_gap;
    logic               r_pkt_done;
    logic [31:0]        r_pkt_count;

    logic               w_cmd_fire;
    logic               w_beat_fire;
    logic               w_last;
    logic               w_eop_fire;

    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_beat_fire = valid && ready;
    assign w_last      = (r_rem <= LEN_W'(DATA_BYTES));
    assign w_eop_fire  = (r_state == S_SEND) && w_beat_fire && w_last;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire && (cmd_len != '0)) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (w_beat_fire && w_last) begin
                    w_next_state = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == 8'd0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Packet cursor: bytes still to send and the payload value of the beat's byte 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem  <= '0;
            r_byte <= 8'd0;
            r_sop  <= 1'b0;
            r_gap  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire && (cmd_len != '0)) begin
                        r_rem  <= cmd_len;
                        r_byte <= cmd_seed;
                        r_sop  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_beat_fire) begin
                        r_sop <= 1'b0;
                        if (w_last) begin
                            r_gap <= GAP_LOAD;
                        end else begin
                            r_rem  <= r_rem - LEN_W'(DATA_BYTES);
                            r_byte <= r_byte + 8'(DATA_BYTES);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap != 8'd0) begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_done  <= 1'b0;
            r_pkt_count <= 32'd0;
        end else begin
            r_pkt_done <= w_eop_fire;
            if (w_eop_fire) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        cmd_ready     = 1'b0;
        valid         = 1'b0;
        startofpacket = 1'b0;
        endofpacket   = 1'b0;
        empty         = '0;
        data          = '0;
        case (r_state)
            S_IDLE: begin
                // Held low while reset is asserted so no command slips in.
                cmd_ready = !reset;
            end
            S_SEND: begin
                valid         = 1'b1;
                startofpacket = r_sop;
                endofpacket   = w_last;
                if (w_last) begin
                    empty = EMPTY_W'(LEN_W'(DATA_BYTES) - r_rem);
                end
                // Byte 0 sits in the top lane; lanes past the packet end stay zero.
                for (int k = 0; k < DATA_BYTES; k++) begin
                    if (LEN_W'(k) < r_rem) begin
                        data[8*(DATA_BYTES-1-k) +: 8] = r_byte + 8'(k);
                    end
                end
            end
            default: ;
        endcase
    end

    assign pkt_done  = r_pkt_done;
    assign pkt_count = r_pkt_count;

endmodule
